// File: rtl/md5_msg_padder_if.sv
// Word-stream input and 512-bit block output of the MD5 message padder.
// valid/ready: a transfer happens on the rising edge where both are high; the sender holds its payload until then.
interface md5_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/md5_msg_padder.sv
// Packs a little-endian word stream into 512-bit MD5 blocks with RFC 1321 padding
// (0x80 marker, zero fill, 64-bit little-endian bit length).
module md5_msg_padder (
  input  logic              clk,
  input  logic              rst,
  md5_msg_padder_if.slave   bus,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {FILL, OUT_DATA, OUT_PAD, OUT_FINAL} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [31:0]  r_buf [16];
  logic [3:0]   r_ptr;
  logic [63:0]  r_len;
  logic         r_pend80;
  logic         r_first_pend;
  logic         r_init;

  logic         w_accept;
  logic         w_take;
  logic [2:0]   w_nb;
  logic [31:0]  w_masked;
  logic [63:0]  w_len_next;
  logic [6:0]   w_mark_off;
  logic         w_mark_fits;

  assign o_state       = r_state;
  assign bus.in_ready  = (r_state == FILL) && !r_init;
  assign bus.blk_valid = (r_state != FILL);
  assign bus.blk_last  = (r_state == OUT_FINAL);
  assign bus.blk_first = r_first_pend && bus.blk_valid;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_take        = bus.blk_valid && bus.blk_ready;

  // Non-last words always carry four bytes; oversize counts saturate at four.
  always_comb begin
    w_nb = 3'd4;
    if (bus.in_last && (bus.in_nbytes < 3'd4)) w_nb = bus.in_nbytes;
  end

  always_comb begin
    w_masked = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < w_nb)       w_masked[8*b +: 8] = bus.in_data[8*b +: 8];
      else if (3'(b) == w_nb) w_masked[8*b +: 8] = 8'h80;
    end
  end

  assign w_len_next  = r_len + {58'd0, w_nb, 3'd0};
  // Byte offset of the 0x80 marker; 64 means it spills into the next block.
  assign w_mark_off  = {1'b0, r_ptr, 2'b00} + {4'd0, w_nb};
  assign w_mark_fits = (w_mark_off <= 7'd55);

  always_comb begin
    bus.blk_data = '0;
    for (int i = 0; i < 16; i++) bus.blk_data[511-32*i -: 32] = r_buf[i];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (bus.in_last)         w_next = w_mark_fits ? OUT_FINAL : OUT_PAD;
          else if (r_ptr == 4'd15) w_next = OUT_DATA;
        end
      end
      OUT_DATA:  if (w_take) w_next = FILL;
      OUT_PAD:   if (w_take) w_next = OUT_FINAL;
      OUT_FINAL: if (w_take) w_next = FILL;
      default:   w_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_ptr        <= '0;
      r_len        <= '0;
      r_pend80     <= 1'b0;
      r_first_pend <= 1'b1;
      r_init       <= 1'b1;
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_next;
      r_init  <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_len <= w_len_next;
            if (!bus.in_last) begin
              r_buf[r_ptr] <= bus.in_data;
              if (r_ptr != 4'd15) r_ptr <= r_ptr + 4'd1;
            end else begin
              r_buf[r_ptr] <= w_masked;
              // Stale words from an earlier block must not leak into the padding.
              for (int i = 0; i < 16; i++) begin
                if (4'(i) > r_ptr)
                  r_buf[i] <= ((4'(i) == r_ptr + 4'd1) && (w_nb == 3'd4)) ? 32'h80 : 32'h0;
              end
              if ((w_nb == 3'd4) && (r_ptr == 4'd15)) r_pend80 <= 1'b1;
              if (w_mark_fits) begin
                r_buf[14] <= w_len_next[31:0];
                r_buf[15] <= w_len_next[63:32];
              end
            end
          end
        end
        OUT_DATA: begin
          if (w_take) begin
            r_ptr        <= '0;
            r_first_pend <= 1'b0;
          end
        end
        OUT_PAD: begin
          if (w_take) begin
            r_first_pend <= 1'b0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
            r_buf[0]  <= r_pend80 ? 32'h80 : 32'h0;
            r_buf[14] <= r_len[31:0];
            r_buf[15] <= r_len[63:32];
          end
        end
        OUT_FINAL: begin
          if (w_take) begin
            r_ptr        <= '0;
            r_len        <= '0;
            r_pend80     <= 1'b0;
            r_first_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Self-checking bench for md5_msg_padder: byte-level RFC 1321 padding model feeding an expected-block queue.
module tb_md5_msg_padder;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  md5_msg_padder_if bus();

  md5_msg_padder dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [513:0] exp_q[$];   // {first, last, data}
  logic [7:0]   msg_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  logic hold_ready = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check(input string tag, input logic [513:0] obs, input logic [513:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference padding: whole-message byte view, chopped into 64-byte blocks.
  task automatic push_model();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] d;
    int nblk;
    int base;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 0; k < 8; k++) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      d = '0;
      for (int i = 0; i < 16; i++) begin
        base = 64*b + 4*i;
        d[511-32*i -: 32] = {p[base+3], p[base+2], p[base+1], p[base]};
      end
      exp_q.push_back({1'(b == 0), 1'(b == nblk-1), d});
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_ready)      bus.blk_ready = 1'b0;
      else if (rand_ready) bus.blk_ready = ($urandom_range(0, 3) != 0);
      else                 bus.blk_ready = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int cnt = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nbytes = nb;
    while (!bus.in_ready && cnt < 300) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 300) check("in_ready_timeout", 514'(bus.in_ready), 514'(1));
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'($urandom);
    bus.in_nbytes = 3'($urandom_range(0, 7));
  endtask

  task automatic send_msg();
    int n;
    int nfull;
    int rem;
    logic [31:0] w;
    logic zero_tail;
    n     = msg_q.size();
    nfull = n / 4;
    rem   = n % 4;
    zero_tail = (n == 0) || ($urandom_range(0, 3) == 0);
    push_model();
    if (rem != 0 || zero_tail) begin
      for (int i = 0; i < nfull; i++)
        drive_word({msg_q[4*i+3], msg_q[4*i+2], msg_q[4*i+1], msg_q[4*i]}, 1'b0,
                   3'($urandom_range(0, 7)));
      w = 32'($urandom);
      for (int b = 0; b < rem; b++) w[8*b +: 8] = msg_q[4*nfull+b];
      drive_word(w, 1'b1, 3'(rem));
    end else begin
      for (int i = 0; i < nfull; i++)
        drive_word({msg_q[4*i+3], msg_q[4*i+2], msg_q[4*i+1], msg_q[4*i]}, (i == nfull-1),
                   (i == nfull-1) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic make_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin @(posedge clk); c++; end
    check("drain", 514'(exp_q.size()), 514'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  514'(bus.in_ready),  514'(0));
    check({tag, "_blk_valid"}, 514'(bus.blk_valid), 514'(0));
    check({tag, "_blk_fl"},    514'({bus.blk_first, bus.blk_last}), 514'(0));
    check({tag, "_blk_data"},  514'(bus.blk_data),  514'(0));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [513:0] obs;
    forever begin
      @(negedge clk);
      if (!rst && bus.blk_valid && bus.blk_ready) begin
        obs = {bus.blk_first, bus.blk_last, bus.blk_data};
        if (exp_q.size() == 0) check("blk_unexpected", 514'(exp_q.size()), 514'(1));
        else check("blk", obs, exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  localparam logic [511:0] ABC_BLK = {32'h80636261, 416'd0, 32'h00000018, 32'h00000000};

  initial begin
    logic [513:0] snap;
    int c;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_nbytes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
    @(posedge clk); #1;
    check("ready_after_reset", 514'(bus.in_ready), 514'(1));

    // "abc" against the literal block
    exp_q.push_back({1'b1, 1'b1, ABC_BLK});
    drive_word(32'h00636261, 1'b1, 3'd3);
    wait_drain();

    // boundary lengths: empty, 55, 56, 64 followed back-to-back by another message
    make_msg(0);  send_msg();
    make_msg(55); send_msg();
    make_msg(56); send_msg();
    make_msg(64); send_msg();
    make_msg(10); send_msg();
    wait_drain();

    // backpressure: first block held for 10 cycles while the source waits on word 17
    hold_ready = 1'b1;
    make_msg(70);
    fork send_msg(); join_none
    c = 0;
    @(negedge clk);
    while (!bus.blk_valid && c < 200) begin @(negedge clk); c++; end
    check("bp_valid_seen", 514'(bus.blk_valid), 514'(1));
    snap = {bus.blk_first, bus.blk_last, bus.blk_data};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_stable", {bus.blk_first, bus.blk_last, bus.blk_data}, snap);
      check("bp_in_ready", 514'(bus.in_ready), 514'(0));
    end
    hold_ready = 1'b0;
    wait fork;
    wait_drain();

    // random lengths with random consumer stalls
    rand_ready = 1'b1;
    for (int m = 0; m < 12; m++) begin
      make_msg($urandom_range(0, 140));
      send_msg();
    end
    wait_drain();

    // reset mid-message, then "abc" must reproduce the first block exactly
    for (int i = 0; i < 5; i++) drive_word(32'($urandom), 1'b0, 3'd4);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_reset_valid", 514'(bus.blk_valid), 514'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_valid2", 514'(bus.blk_valid), 514'(0));
    @(posedge clk); #1;
    rand_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b1, ABC_BLK});
    drive_word(32'h00636261, 1'b1, 3'd3);
    wait_drain();
    repeat (5) @(posedge clk);
    check("no_extra_blocks", 514'(exp_q.size()), 514'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
